sync_pla_loader: RTL and testbench
==================================

# sync_pla_loader

Synthesizable programmable AND-plane (PLA) with a streaming personality-write port. An upstream controller writes one product-term row per transfer; once loaded, the block evaluates every row against input vector `a` each clock and registers the per-row match bits on `b`. It is the hardware writer/loader counterpart to the file-loaded `$async$and$array`/`$readmemb` PLA model, used where the personality must be delivered at run time.

## Interface
- `N_IN`, 7, number of PLA inputs (columns).
- `N_TERMS`, 3, number of product terms (rows).
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `prog_start`  in  1  single-cycle pulse: clear personality, begin load.
- `prog_valid`  in  1  row data valid.
- `prog_ready`  out  1  block accepts a row.
- `prog_data`  in  2*N_IN  one row; per input i: bit 2i+1 = care, bit 2i = value.
- `prog_last`  in  1  marks final row of a load.
- `a`  in  N_IN  PLA inputs; `a[N_IN-1]` is column 1.
- `b`  out  N_TERMS  registered term outputs; `b[N_TERMS-1]` is row 1.
- `loaded`  out  1  personality load finished, block evaluating.
- `prog_err`  out  1  last load had a row-count mismatch; sticky until next `prog_start`/`rst`.

## Operation
- States: IDLE (unprogrammed), LOAD, RUN.
- Reset: state IDLE, all row-valid bits 0, row counter 0; `b`=0, `prog_ready`=0, `loaded`=0, `prog_err`=0.
- `prog_start` in any state: next cycle state LOAD, row-valid all 0, counter 0, `prog_err`=0, `loaded`=0, `b`=0. `prog_start` has priority over a concurrent transfer (that row is dropped).
- `prog_ready`=1 only in LOAD. Transfer = `prog_valid && prog_ready`: row[counter] ← `prog_data`, row-valid[counter] ← 1, counter+1.
- Load ends on a transfer with `prog_last`=1 or on transfer of row N_TERMS (index N_TERMS-1), whichever first; next state RUN, `loaded`=1.
- `prog_err` set when ending transfer has `prog_last`=1 but counter ≠ N_TERMS-1 (short load; unwritten rows stay invalid), or row N_TERMS transferred with `prog_last`=0 (missing last).
- Row match: AND over i of (!care_i || a[i]==value_i). All-care-0 row (`???`) always matches. Invalid rows never match.
- RUN: `b[r]` ← row-valid[r] & match(r) every cycle. IDLE/LOAD: `b` held 0.
- Counter width $clog2(N_TERMS+1); never wraps (load terminates at N_TERMS).

## Timing
- `a` sampled at edge k → `b` updated at edge k (visible after k); latency 1 cycle, throughput 1 vector/cycle.
- `prog_start` at edge k → `prog_ready`=1 after edge k.
- Ending transfer at edge k → `loaded`=1, `prog_ready`=0 after edge k; first valid `b` after edge k+1.
- `rst` mid-load or mid-run: all state returns to reset values at that edge; `rst` beats `prog_start`.
- `prog_valid` in IDLE/RUN ignored.

## Structure
- Package `sync_pla_pkg`: state enum (`PLA_IDLE`, `PLA_LOAD`, `PLA_RUN`), care/value bit-offset localparams, function `term_match(row, a)`.
- One sub-module: `pla_and_term` (one row register + valid bit + match logic), generated N_TERMS times; top holds FSM, counter, error logic.

## Test plan
- Reset, N_IN=3, N_TERMS=4: after `rst` `b`=0, `loaded`=0, `prog_ready`=0; `prog_valid` pulses ignored.
- Load 10?, ??1, 0?0, ??? as 6'b111000, 6'b000011, 6'b100010, 6'b000000 (last on 4th) → `loaded`=1, `prog_err`=0; a=111→`b`=0101, a=000→0011, a=101→1101, each one cycle after `a`.
- Short load: 2 rows with `prog_last` on 2nd → `prog_err`=1; a=101 → `b`=1100 (rows 3–4 invalid).
- Missing last: 4 rows, `prog_last`=0 throughout → RUN after 4th, `prog_err`=1, `prog_ready`=0, 5th `prog_valid` ignored.
- Back-pressure/priority: `prog_valid` gaps mid-load keep counter; `prog_start` coincident with transfer → row dropped, counter 0, `b`=0.
- `rst` asserted mid-load after 2 rows → all outputs at reset values next cycle; fresh load then behaves as scenario 2.

Source files
------------

// File: rtl/sync_pla_pkg.sv
// Shared types and helpers for the streaming-loaded PLA AND-plane.
// A personality row holds one (care, value) bit pair per input column.
package sync_pla_pkg;

    typedef enum logic [1:0] {
        PLA_IDLE = 2'd0,
        PLA_LOAD = 2'd1,
        PLA_RUN  = 2'd2
    } pla_state_e;

    localparam int PLA_VAL_OFS  = 0;
    localparam int PLA_CARE_OFS = 1;

    // term_match works on a fixed maximum width; callers zero-extend, and a zero
    // care bit in the padding means those columns always match.
    localparam int PLA_MAX_IN = 64;
    localparam int PLA_ROW_W  = 2 * PLA_MAX_IN;

    function automatic logic term_match(input logic [PLA_ROW_W-1:0]  row,
                                        input logic [PLA_MAX_IN-1:0] a);
        logic m;
        m = 1'b1;
        for (int i = 0; i < PLA_MAX_IN; i++) begin
            if (row[2*i+PLA_CARE_OFS] && (a[i] != row[2*i+PLA_VAL_OFS])) begin
                m = 1'b0;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/sync_pla_loader_if.sv
// Personality-write stream: start pulse, one row per valid/ready transfer.
interface sync_pla_loader_if #(
    parameter int N_IN = 7
);
    logic                prog_start;
    logic                prog_valid;
    logic                prog_ready;
    logic [2*N_IN-1:0]   prog_data;
    logic                prog_last;

    modport master (
        output prog_start,
        output prog_valid,
        output prog_data,
        output prog_last,
        input  prog_ready
    );

    modport slave (
        input  prog_start,
        input  prog_valid,
        input  prog_data,
        input  prog_last,
        output prog_ready
    );
endinterface

// File: rtl/sync_pla_loader_term.sv
// One PLA product term: row register, row-valid bit, match logic and the
// registered term output.
module pla_and_term
    import sync_pla_pkg::*;
#(
    parameter int N_IN = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_wr,
    input  logic [2*N_IN-1:0] i_data,
    input  logic [N_IN-1:0]   i_a,
    input  logic              i_run,
    output logic              o_b
);

    logic [2*N_IN-1:0] r_row;
    logic              r_valid;
    logic              r_b;
    logic              w_match;

    // NOTE: the row store is deliberately left out of reset; r_valid gates it,
    // so whatever it holds before its first write can never reach o_b.
    always_ff @(posedge clk) begin
        if (i_wr) begin
            r_row <= i_data;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop sees
    // the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_b     <= 1'b0;
        end else begin
            if (i_clear) begin
                r_valid <= 1'b0;
            end else if (i_wr) begin
                r_valid <= 1'b1;
            end
            r_b <= !i_clear && i_run && r_valid && w_match;
        end
    end

    assign w_match = term_match(PLA_ROW_W'(r_row), PLA_MAX_IN'(i_a));
    assign o_b     = r_b;

endmodule

// File: rtl/sync_pla_loader.sv
// Run-time loadable PLA AND-plane: load FSM, row counter and error tracking,
// with N_TERMS term slices evaluating input vector a every cycle once loaded.
module sync_pla_loader
    import sync_pla_pkg::*;
#(
    parameter int N_IN    = 7,
    parameter int N_TERMS = 3
) (
    input  logic                clk,
    input  logic                rst,
    sync_pla_loader_if.slave    prog,
    input  logic [N_IN-1:0]     a,
    output logic [N_TERMS-1:0]  b,
    output logic                loaded,
    output logic                prog_err
);

    localparam int               CNT_W    = $clog2(N_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TERMS - 1);

    pla_state_e       r_state;
    pla_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_ready;
    logic             w_run;
    logic             w_at_last;
    logic             w_xfer;
    logic             w_end;

    assign w_ready   = (r_state == PLA_LOAD);
    assign w_run     = (r_state == PLA_RUN);
    assign w_at_last = (r_cnt == LAST_IDX);
    // A start pulse wins over a coincident transfer; that row is dropped.
    assign w_xfer    = prog.prog_valid && w_ready && !prog.prog_start;
    assign w_end     = w_xfer && (prog.prog_last || w_at_last);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        if (prog.prog_start) begin
            w_state_nxt = PLA_LOAD;
            w_cnt_nxt   = '0;
            w_err_nxt   = 1'b0;
        end else begin
            case (r_state)
                PLA_LOAD: begin
                    if (w_xfer) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                    if (w_end) begin
                        w_state_nxt = PLA_RUN;
                        // Error when last flag and row count disagree.
                        w_err_nxt   = (prog.prog_last != w_at_last);
                    end
                end
                PLA_IDLE, PLA_RUN: begin
                end
                default: begin
                    w_state_nxt = PLA_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PLA_IDLE;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Row index 0 is the first row written, reported on the MSB of b.
    for (genvar r = 0; r < N_TERMS; r++) begin : g_term
        pla_and_term #(
            .N_IN (N_IN)
        ) u_term (
            .clk     (clk),
            .rst     (rst),
            .i_clear (prog.prog_start),
            .i_wr    (w_xfer && (r_cnt == CNT_W'(r))),
            .i_data  (prog.prog_data),
            .i_a     (a),
            .i_run   (w_run),
            .o_b     (b[N_TERMS-1-r])
        );
    end

    assign prog.prog_ready = w_ready;
    assign loaded          = w_run;
    assign prog_err        = r_err;

endmodule

// File: tb/tb_sync_pla_loader.sv
// Scoreboard bench for sync_pla_loader (N_IN=3, N_TERMS=4): stimulus queues
// expected {b, loaded, prog_ready, prog_err} per cycle, a monitor compares.
module tb_sync_pla_loader;

    localparam int N_IN    = 3;
    localparam int N_TERMS = 4;

    localparam logic [5:0] ROW_10X = 6'b111000;
    localparam logic [5:0] ROW_XX1 = 6'b000011;
    localparam logic [5:0] ROW_0X0 = 6'b100010;
    localparam logic [5:0] ROW_XXX = 6'b000000;

    typedef struct {
        int          tag;
        string       name;
        logic [6:0]  exp;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [N_IN-1:0]    a;
    logic [N_TERMS-1:0] b;
    logic               loaded;
    logic               prog_err;

    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_bad  = 0;
    exp_t q[$];

    sync_pla_loader_if #(.N_IN(N_IN)) pif ();

    sync_pla_loader #(
        .N_IN    (N_IN),
        .N_TERMS (N_TERMS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .prog     (pif),
        .a        (a),
        .b        (b),
        .loaded   (loaded),
        .prog_err (prog_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got b/ld/rdy/err=%b expected %b", name, act, exp);
        end
    endtask

    // Monitor: compares every queued expectation due in the current cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() != 0 && q[0].tag <= cyc) begin
                e = q.pop_front();
                if (e.tag < cyc) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL %s: got missed cycle %0d expected cycle %0d", e.name, cyc, e.tag);
                end else begin
                    check(e.name, {b, loaded, pif.prog_ready, prog_err}, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string name, input logic [3:0] eb,
                              input logic el, input logic er, input logic ee);
        exp_t e;
        e.tag  = cyc;
        e.name = name;
        e.exp  = {eb, el, er, ee};
        q.push_back(e);
    endtask

    task automatic start(input string name);
        pif.prog_start = 1'b1;
        tick();
        pif.prog_start = 1'b0;
        expect_now(name, 4'b0000, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic send(input logic [5:0] data, input logic last);
        pif.prog_valid = 1'b1;
        pif.prog_data  = data;
        pif.prog_last  = last;
        tick();
        pif.prog_valid = 1'b0;
        pif.prog_last  = 1'b0;
    endtask

    task automatic eval_full_set(input string tag);
        a = 3'b111; tick(); expect_now({tag, "_a111"}, 4'b0101, 1'b1, 1'b0, 1'b0);
        a = 3'b000; tick(); expect_now({tag, "_a000"}, 4'b0011, 1'b1, 1'b0, 1'b0);
        a = 3'b101; tick(); expect_now({tag, "_a101"}, 4'b1101, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        a              = '0;
        pif.prog_start = 1'b0;
        pif.prog_valid = 1'b0;
        pif.prog_data  = '0;
        pif.prog_last  = 1'b0;
        tick();
        tick();
        expect_now("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        send(6'b111111, 1'b1);
        expect_now("idle_valid_ignored", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Full load with a gap after the first row.
        start("start_full");
        send(ROW_10X, 1'b0);
        expect_now("full_row1", 4'b0000, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        expect_now("full_gap_hold", 4'b0000, 1'b0, 1'b1, 1'b0);
        send(ROW_XX1, 1'b0);
        send(ROW_0X0, 1'b0);
        send(ROW_XXX, 1'b1);
        expect_now("full_loaded", 4'b0000, 1'b1, 1'b0, 1'b0);
        eval_full_set("full");

        // Short load: two rows, last on the second.
        start("start_short");
        send(ROW_10X, 1'b0);
        send(ROW_XX1, 1'b1);
        expect_now("short_end", 4'b0000, 1'b1, 1'b0, 1'b1);
        tick();
        expect_now("short_a101", 4'b1100, 1'b1, 1'b0, 1'b1);
        tick();
        expect_now("short_err_sticky", 4'b1100, 1'b1, 1'b0, 1'b1);

        // Missing last: four rows without prog_last, then a fifth offered.
        start("start_missing");
        send(ROW_10X, 1'b0);
        send(ROW_XX1, 1'b0);
        send(ROW_0X0, 1'b0);
        send(ROW_XXX, 1'b0);
        expect_now("missing_end", 4'b0000, 1'b1, 1'b0, 1'b1);
        send(ROW_XXX, 1'b1);
        expect_now("missing_fifth_ignored", 4'b1101, 1'b1, 1'b0, 1'b1);
        tick();
        expect_now("missing_run_hold", 4'b1101, 1'b1, 1'b0, 1'b1);

        // prog_start coincident with a transfer drops that row and restarts at 0.
        start("start_prio");
        send(ROW_10X, 1'b0);
        pif.prog_start = 1'b1;
        pif.prog_valid = 1'b1;
        pif.prog_data  = ROW_XXX;
        pif.prog_last  = 1'b1;
        tick();
        pif.prog_start = 1'b0;
        pif.prog_valid = 1'b0;
        pif.prog_last  = 1'b0;
        expect_now("prio_start_wins", 4'b0000, 1'b0, 1'b1, 1'b0);
        send(ROW_XX1, 1'b1);
        expect_now("prio_end", 4'b0000, 1'b1, 1'b0, 1'b1);
        tick();
        expect_now("prio_counter_zero", 4'b1000, 1'b1, 1'b0, 1'b1);

        // Reset mid-load, reset beating start, then a fresh full load.
        start("start_rst");
        send(ROW_10X, 1'b0);
        send(ROW_XX1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_now("rst_mid_load", 4'b0000, 1'b0, 1'b0, 1'b0);
        rst            = 1'b1;
        pif.prog_start = 1'b1;
        tick();
        rst            = 1'b0;
        pif.prog_start = 1'b0;
        expect_now("rst_beats_start", 4'b0000, 1'b0, 1'b0, 1'b0);
        start("start_fresh");
        send(ROW_10X, 1'b0);
        send(ROW_XX1, 1'b0);
        send(ROW_0X0, 1'b0);
        send(ROW_XXX, 1'b1);
        expect_now("fresh_loaded", 4'b0000, 1'b1, 1'b0, 1'b0);
        eval_full_set("fresh");

        tick();
        tick();
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            n_bad++;
            $display("FAIL %s: got unchecked expected checked", e.name);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
